rmap_rx_packet_fifo: RTL and testbench
======================================

Name: rmap_rx_packet_fifo

Overview:
Store-and-forward receive FIFO that sits directly upstream of the RMAP target. It feeds the target's rxReadEnable/rxDataOut/rxEmpty port. It buffers SpaceWire N-Chars from the codec and exposes only complete packets (terminated by EOP or EEP) to the reader. A packet that overflows the buffer is discarded whole, so the target never sees a truncated packet.

Parameters:
DEPTH_LOG2, 11, log2 of storage depth in N-Chars (DEPTH = 2**DEPTH_LOG2)
DATA_WIDTH, 9, N-Char width: bit 8 = control flag, bits 7:0 = data/control code

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wrEnable  in  1  write strobe from codec
wrData  in  DATA_WIDTH  N-Char to store
wrFull  out  1  advisory: buffer full while in ACCEPT state
rdEnable  in  1  read strobe from RMAP target
rdData  out  DATA_WIDTH  registered read data
rdEmpty  out  1  no committed N-Char available
packetCount  out  DEPTH_LOG2+1  complete packets currently stored
droppedPulse  out  1  one-cycle pulse per discarded packet
dropCount  out  16  discarded packets, saturating at 0xFFFF

Behaviour:
- Reset (synchronous, active-high), applied on clk edge with rst=1:
  - wrPtr, commitPtr, rdPtr = 0; state = ACCEPT.
  - rdData = 0, rdEmpty = 1, wrFull = 0, packetCount = 0, dropCount = 0, droppedPulse = 0.
  - Reset mid-packet discards all contents, committed or not.
- Pointers are DEPTH_LOG2+1 bits with a wrap bit; memory is indexed by the low DEPTH_LOG2 bits.
- full = (wrPtr - rdPtr == DEPTH); rdEmpty = (rdPtr == commitPtr); wrFull = full && state==ACCEPT.
- Terminator: any N-Char with bit 8 = 1. 0x100 = EOP, 0x101 = EEP; any other control code is treated as EEP-class and stored verbatim.
- Write FSM, ACCEPT state:
  - wrEnable && !full: mem[wrPtr] <= wrData; wrPtr++.
    - If wrData is a terminator: commitPtr <= wrPtr+1 and packetCount++ (same edge).
  - wrEnable && full (overflow): wrPtr <= commitPtr; droppedPulse = 1 next cycle; dropCount++ (saturating).
    - If the offending char is a terminator, stay in ACCEPT; otherwise go to DISCARD.
- Write FSM, DISCARD state:
  - All writes are swallowed; wrFull = 0.
  - A terminator write returns the FSM to ACCEPT; that terminator is not stored.
- The FIFO never back-pressures. wrFull is advisory; writing while full causes a drop.
- Any packet longer than DEPTH is always dropped.
- Full is evaluated on registered pointers. A read in the same cycle does not free space for a write (no bypass).
- Visibility latency: a terminator written on edge N clears rdEmpty after edge N. The reader can assert rdEnable in cycle N+1. Chars of an uncommitted packet are never visible.
- Read side:
  - rdEnable && !rdEmpty: rdData <= mem[rdPtr] (valid the cycle after the strobe); rdPtr++.
  - If the char read is a terminator, packetCount-- on that edge.
  - rdEnable while empty is ignored; rdPtr and rdData hold.
- Simultaneous commit and terminator read: packetCount unchanged.
- Overflow and terminator read in the same cycle: packetCount-- only.

Decomposition:
- Package rmap_rx_pkg:
  - EOP_CHAR = 9'h100, EEP_CHAR = 9'h101.
  - typedef enum logic {ACCEPT, DISCARD} wr_state_e.
  - function is_terminator(nchar).
- Sub-module sdp_ram:
  - Simple dual-port RAM, parameters DEPTH_LOG2/DATA_WIDTH.
  - One write port, one read port with registered output.
  - Holds all storage; pointer and FSM logic stay in the top.

Test Plan:
1. Single packet: write 0x0FE, 0x001, 0x04C, 0x100.
   - rdEmpty stays 1 until the edge that stores 0x100, then drops.
   - packetCount = 1.
   - Four reads return 0x0FE, 0x001, 0x04C, 0x100; packetCount returns to 0 and rdEmpty = 1.
2. Overflow (DEPTH_LOG2=4): commit a 10-char packet, then write a 10-char packet.
   - On the 7th char: droppedPulse for one cycle, dropCount = 1, wrPtr back at 10, FSM in DISCARD.
   - Chars 8-10 are swallowed and the FSM returns to ACCEPT.
   - Only the first packet is readable.
3. EEP termination: write 0x0AA, 0x101.
   - Packet commits; reads return 0x0AA, 0x101; packetCount 1 → 0.
4. Simultaneous events: with packet A (ending 0x100) being read, issue A's terminator read on the same edge as packet B's EOP write.
   - packetCount stays 1.
   - rdEmpty stays 0; B is readable next.
5. Reset mid-packet: write 5 data chars with no terminator, then assert rst for one cycle.
   - rdEmpty = 1, packetCount = 0.
   - A subsequent packet 0x011, 0x100 reads back exactly.
6. Read while empty: pulse rdEnable for 3 cycles on an empty FIFO after reading 0x100.
   - rdData holds 0x100; rdPtr is unchanged; packetCount = 0.

Source files
------------

// File: rtl/rmap_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rmap_rx_pkg
//  Purpose  : Shared N-Char constants, write-FSM states and helpers for the
//             RMAP receive packet FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package rmap_rx_pkg;

    localparam int NCHAR_W = 9;

    localparam logic [NCHAR_W-1:0] EOP_CHAR = 9'h100;
    localparam logic [NCHAR_W-1:0] EEP_CHAR = 9'h101;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_e;

    // Every control character ends a packet; non-EOP codes count as EEP-class.
    function automatic logic is_terminator(input logic [NCHAR_W-1:0] nchar);
        return nchar[NCHAR_W-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_ram
//  Purpose  : Simple dual-port RAM, one write port and one registered read
//             port, plus an unregistered peek of the current read address.
//  Revision : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int DEPTH_LOG2 = 11,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rd_peek
);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
    assign rd_peek = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/rmap_rx_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rmap_rx_packet_fifo
//  Purpose  : Store-and-forward SpaceWire receive FIFO exposing only complete
//             packets; an overflowing packet is discarded whole.
//  Revision : 1.0 - initial release
// ============================================================================
module rmap_rx_packet_fifo
    import rmap_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEnable,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  wrFull,
    input  logic                  rdEnable,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdEmpty,
    output logic [DEPTH_LOG2:0]   packetCount,
    output logic                  droppedPulse,
    output logic [15:0]           dropCount
);

    localparam int                 c_PTR_W = DEPTH_LOG2 + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

    wr_state_e             r_state;
    wr_state_e             w_state_next;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_commit_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_packet_count;
    logic [15:0]           r_drop_count;
    logic                  r_dropped_pulse;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_term;
    logic                  w_store;
    logic                  w_overflow;
    logic                  w_commit;
    logic                  w_rd_fire;
    logic                  w_rd_term;
    logic [DATA_WIDTH-1:0] w_rd_peek;

    // Occupancy counts uncommitted chars too, so a long packet fills the
    // buffer and gets dropped rather than ever becoming visible.
    assign w_full    = (r_wr_ptr - r_rd_ptr) == c_DEPTH;
    assign w_empty   = (r_rd_ptr == r_commit_ptr);
    assign w_wr_term = is_terminator(wrData);
    assign w_commit  = w_store && w_wr_term;
    assign w_rd_fire = rdEnable && !w_empty;
    assign w_rd_term = w_rd_fire && is_terminator(w_rd_peek);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_store      = 1'b0;
        w_overflow   = 1'b0;
        unique case (r_state)
            ACCEPT: begin
                if (wrEnable) begin
                    if (w_full) begin
                        w_overflow = 1'b1;
                        if (!w_wr_term) begin
                            w_state_next = DISCARD;
                        end
                    end else begin
                        w_store = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (wrEnable && w_wr_term) begin
                    w_state_next = ACCEPT;
                end
            end
            default: w_state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_commit_ptr    <= '0;
            r_rd_ptr        <= '0;
            r_packet_count  <= '0;
            r_drop_count    <= '0;
            r_dropped_pulse <= 1'b0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
                if (w_commit) begin
                    r_commit_ptr <= r_wr_ptr + c_ONE;
                end
            end else if (w_overflow) begin
                r_wr_ptr <= r_commit_ptr;
            end

            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end

            unique case ({w_commit, w_rd_term})
                2'b10:   r_packet_count <= r_packet_count + 1'b1;
                2'b01:   r_packet_count <= r_packet_count - 1'b1;
                default: r_packet_count <= r_packet_count;
            endcase

            r_dropped_pulse <= w_overflow;
            if (w_overflow && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    sdp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_store),
        .wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (wrData),
        .rd_en   (w_rd_fire),
        .rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rdData),
        .rd_peek (w_rd_peek)
    );

    assign wrFull       = w_full && (r_state == ACCEPT);
    assign rdEmpty      = w_empty;
    assign packetCount  = r_packet_count;
    assign droppedPulse = r_dropped_pulse;
    assign dropCount    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_rmap_rx_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rmap_rx_packet_fifo
//  Purpose  : Scoreboard bench for the RMAP receive packet FIFO against a
//             queue-based packet model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rmap_rx_packet_fifo;
    import rmap_rx_pkg::*;

    localparam int DL    = 4;
    localparam int DW    = 9;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wrEnable = 1'b0;
    logic [DW-1:0] wrData = '0;
    logic          wrFull;
    logic          rdEnable = 1'b0;
    logic [DW-1:0] rdData;
    logic          rdEmpty;
    logic [DL:0]   packetCount;
    logic          droppedPulse;
    logic [15:0]   dropCount;

    always #5 clk = ~clk;

    rmap_rx_packet_fifo #(
        .DEPTH_LOG2 (DL),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wrEnable     (wrEnable),
        .wrData       (wrData),
        .wrFull       (wrFull),
        .rdEnable     (rdEnable),
        .rdData       (rdData),
        .rdEmpty      (rdEmpty),
        .packetCount  (packetCount),
        .droppedPulse (droppedPulse),
        .dropCount    (dropCount)
    );

    int errors = 0;
    int checks = 0;

    // Model: committed chars readable in order, chars of the packet in flight,
    // and whether the remainder of an overflowed packet is being swallowed.
    int exp_q[$];
    int mq[$];
    int pq[$];
    bit disc   = 1'b0;
    int mdrop  = 0;
    bit mpulse = 1'b0;
    int mlast  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int count_terms();
        int n = 0;
        foreach (mq[i]) if (mq[i] >= 256) n++;
        return n;
    endfunction

    task automatic cyc(input bit r, input bit we, input int wd, input bit re);
        int occ;
        int v;
        @(negedge clk);
        rst      = r;
        wrEnable = we;
        wrData   = wd[8:0];
        rdEnable = re;
        @(posedge clk);
        if (r) begin
            mq.delete();
            pq.delete();
            disc   = 1'b0;
            mdrop  = 0;
            mpulse = 1'b0;
            mlast  = 0;
        end else begin
            occ    = mq.size() + pq.size();
            mpulse = 1'b0;
            if (re && mq.size() > 0) begin
                v = mq.pop_front();
                exp_q.push_back(v);
                mlast = v;
            end
            if (we) begin
                if (disc) begin
                    if (wd >= 256) disc = 1'b0;
                end else if (occ == DEPTH) begin
                    pq.delete();
                    mpulse = 1'b1;
                    if (mdrop < 65535) mdrop++;
                    disc = (wd < 256);
                end else begin
                    pq.push_back(wd);
                    if (wd >= 256) begin
                        foreach (pq[i]) mq.push_back(pq[i]);
                        pq.delete();
                    end
                end
            end
        end
        #1;
        chk("rdEmpty", int'(rdEmpty), int'(mq.size() == 0));
        chk("packetCount", int'(packetCount), count_terms());
        chk("dropCount", int'(dropCount), mdrop);
        chk("droppedPulse", int'(droppedPulse), int'(mpulse));
        chk("wrFull", int'(wrFull), int'(!disc && (mq.size() + pq.size() == DEPTH)));
        chk("rdData_hold", int'(rdData), mlast);
    endtask

    task automatic wr(input int wd);
        cyc(1'b0, 1'b1, wd, 1'b0);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b1);
    endtask

    // Monitor: whenever the DUT accepts a read strobe, the data it presents
    // after that edge must match the next scoreboard entry.
    initial begin : monitor
        bit fire;
        forever begin
            @(negedge clk);
            #4;
            fire = rdEnable && !rdEmpty && !rst;
            @(posedge clk);
            #2;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: got %0h expected no read", rdData);
                end else begin
                    chk("read_data", int'(rdData), exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        int we_pct;
        int rd_pct;
        int term_pct;
        int wd;
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);

        // Single EOP packet
        wr('h0FE); wr('h001); wr('h04C); wr(EOP_CHAR);
        rd(4);
        cyc(1'b0, 1'b0, 0, 1'b0);

        // Overflow: 10-char packet commits, the next one dies on its 7th char
        for (int i = 0; i < 9; i++) wr(i + 1);
        wr(EOP_CHAR);
        for (int i = 0; i < 9; i++) wr('h20 + i);
        wr(EOP_CHAR);
        rd(11);

        // EEP termination
        wr('h0AA); wr(EEP_CHAR);
        rd(2);

        // Terminator read on the same edge as the next packet's commit
        wr('h033); wr(EOP_CHAR);
        rd(1);
        wr('h044);
        cyc(1'b0, 1'b1, EOP_CHAR, 1'b1);
        rd(2);

        // Reset in the middle of an unterminated packet
        for (int i = 0; i < 5; i++) wr('h050 + i);
        cyc(1'b1, 1'b0, 0, 1'b0);
        wr('h011); wr(EOP_CHAR);
        rd(2);

        // Reads on an empty FIFO are ignored
        rd(3);

        // Randomized phases with varying write/read/terminator densities
        for (int p = 0; p < 8; p++) begin
            we_pct   = $urandom_range(30, 95);
            rd_pct   = $urandom_range(5, 90);
            term_pct = (p % 3 == 0) ? 3 : $urandom_range(8, 30);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 99) < term_pct) begin
                    case ($urandom_range(0, 2))
                        0:       wd = EOP_CHAR;
                        1:       wd = EEP_CHAR;
                        default: wd = 'h100 | $urandom_range(0, 255);
                    endcase
                end else begin
                    wd = $urandom_range(0, 255);
                end
                cyc($urandom_range(0, 999) == 0, $urandom_range(0, 99) < we_pct,
                    wd, $urandom_range(0, 99) < rd_pct);
            end
        end

        // Drain everything committed, then confirm every read was checked
        rd(DEPTH + 2);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
